vector_op_sequencer: RTL and testbench
======================================

Name: vector_op_sequencer

Overview:
- Issue-stage controller between instruction decode and the vector datapath.
- Accepts one decoded instruction through a valid/ready handshake and classifies it by its 5-bit EX control field (funct, opcode[2:0], imm).
- Sequences the instruction element-by-element across VLEN lanes, driving the ALU, divider and memory enables plus the scalar and vector register write enables.
- Holds the front end stalled until the instruction retires.

Parameters:
- VLEN, 8, number of vector elements per instruction; must be ≥2.
- IDXW, $clog2(VLEN), element index width; derived, never overridden.
- CNTW, 16, width of the performance counters; used only with VSEQ_PERF_CNT_EN.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  decoded instruction present on ex_ctrl.
- issue_ready  out  1  sequencer can accept an instruction this cycle.
- ex_ctrl  in  5  {funct, opcode[2:0], imm}; sampled only on handshake.
- div_done  in  1  divider result for the current element is valid.
- mem_ack  in  1  memory completed the current element access.
- elem_idx  out  IDXW  current element index.
- alu_en  out  1  ALU operates this cycle.
- div_start  out  1  one-cycle divider launch pulse.
- mem_req  out  1  memory access request for elem_idx.
- mem_we  out  1  store qualifier; asserted only while mem_req=1.
- sreg_we  out  1  scalar register write enable.
- vreg_we  out  1  vector register write enable for elem_idx.
- stall  out  1  high whenever state != IDLE.
- done  out  1  one-cycle retire pulse.

Behaviour:
- Instruction classes, latched on the handshake (issue_valid & issue_ready):
  - funct=1 → MEM; opcode[0]=1 is a store, 0 is a load.
  - funct=0, opcode 000/010/011 → SCALAR.
  - funct=0, opcode 001/100/101 → VEC.
  - funct=0, opcode 110 → DIV.
  - funct=0, opcode 111 → ILLEGAL: goes straight to FIN with no enables asserted.
- States:
  - IDLE: issue_ready=1. On handshake, latch class and store flag, clear elem_idx, go to the class state.
  - SCALAR: alu_en=1, sreg_we=1 for exactly one cycle → FIN.
  - VEC: alu_en=1, vreg_we=1 every cycle. At elem_idx=VLEN-1 → FIN; otherwise elem_idx+1.
  - DIV_START: div_start=1 for one cycle → DIV_WAIT. A div_done seen in DIV_START is ignored.
  - DIV_WAIT: waits indefinitely. On div_done, vreg_we=1 that cycle; then at the last element → FIN, otherwise elem_idx+1 → DIV_START.
  - MEM: mem_req=1; elem_idx and mem_we stay stable until mem_ack. In the mem_ack cycle, a load also asserts vreg_we=1; then at the last element → FIN, otherwise elem_idx+1. mem_req is permitted to stay high across consecutive elements.
  - FIN: done=1 for one cycle, issue_ready=0 → IDLE.
- Latencies, counted from the handshake cycle T:
  - VEC: vreg_we in T+1..T+VLEN, done at T+VLEN+1, next accept possible at T+VLEN+2.
  - SCALAR: done at T+2.
  - ILLEGAL: done at T+1.
- Outputs decode combinationally from state and registered datapath. No output is asserted outside the state that defines it.
- Reset behaviour:
  - With rst high at an edge: state=IDLE, elem_idx=0, latched class cleared.
  - While rst is high, every output is forced to 0, including issue_ready.
  - Reset mid-operation aborts the instruction with no done pulse. mem_req and div_start are low from the first reset cycle, and any late mem_ack or div_done is ignored.
- Boundaries:
  - issue_valid while not ready is ignored; upstream holds ex_ctrl.
  - ex_ctrl changing after the handshake has no effect.
  - elem_idx never exceeds VLEN-1 and never wraps inside an instruction.
  - A mem_ack arriving without mem_req is ignored.

Optional Feature:
- Macro: VSEQ_PERF_CNT_EN.
- Defined:
  - Adds output ports instr_count and busy_cycles, each CNTW bits.
  - instr_count increments on every done pulse.
  - busy_cycles increments on every cycle with stall=1.
  - Both counters saturate at all-ones and clear on rst.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then VEC op ex_ctrl=5'b01010 (opcode 101), VLEN=8, handshake at T → vreg_we high T+1..T+8 with elem_idx 0..7, done at T+9, issue_ready at T+10.
- SCALAR op ex_ctrl=5'b00101 → alu_en=sreg_we=1 only at T+1, done at T+2, vreg_we never high.
- DIV op with div_done returned 3 cycles after each div_start → 8 div_start pulses, 8 vreg_we pulses aligned to div_done, done one cycle after the 8th.
- Store ex_ctrl=5'b10010 with mem_ack delayed 2 cycles for element 3 → mem_req and mem_we held and elem_idx=3 stable until ack, vreg_we never high; load repeat → vreg_we high on each ack.
- rst asserted during VEC at elem_idx=4 → all outputs 0 next cycle, no done; after release issue_ready=1 and a fresh VEC op starts at elem_idx=0.
- ILLEGAL ex_ctrl=5'b01110 → done at T+1 and no enables; with VSEQ_PERF_CNT_EN, instr_count=1 and busy_cycles=1.

Source files
------------

// File: rtl/vector_op_sequencer_if.sv
// Issue/execute bundle between instruction decode, vector_op_sequencer and the
// vector datapath. "master" is the decode/datapath side, "slave" the sequencer.
interface vector_op_sequencer_if #(
  parameter int VLEN = 8
);
  localparam int IDXW = $clog2(VLEN);

  logic            issue_valid;
  logic            issue_ready;
  logic [4:0]      ex_ctrl;
  logic            div_done;
  logic            mem_ack;
  logic [IDXW-1:0] elem_idx;
  logic            alu_en;
  logic            div_start;
  logic            mem_req;
  logic            mem_we;
  logic            sreg_we;
  logic            vreg_we;
  logic            stall;
  logic            done;

  modport master (
    output issue_valid, ex_ctrl, div_done, mem_ack,
    input  issue_ready, elem_idx, alu_en, div_start, mem_req, mem_we,
           sreg_we, vreg_we, stall, done
  );

  modport slave (
    input  issue_valid, ex_ctrl, div_done, mem_ack,
    output issue_ready, elem_idx, alu_en, div_start, mem_req, mem_we,
           sreg_we, vreg_we, stall, done
  );
endinterface

// File: rtl/vector_op_sequencer.sv
// Issue-stage sequencer: accepts one decoded instruction and walks it across VLEN
// elements. Define VSEQ_PERF_CNT_EN to add saturating instr_count/busy_cycles counters.
module vector_op_sequencer #(
  parameter int VLEN = 8
`ifdef VSEQ_PERF_CNT_EN
  , parameter int CNTW = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef VSEQ_PERF_CNT_EN
  output logic [CNTW-1:0]       instr_count,
  output logic [CNTW-1:0]       busy_cycles,
`endif
  vector_op_sequencer_if.slave  bus
);

  localparam int              IDXW     = $clog2(VLEN);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(VLEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCALAR,
    S_VEC,
    S_DIV_START,
    S_DIV_WAIT,
    S_MEM,
    S_FIN
  } state_t;

  state_t          state_q, state_d, accept_state;
  logic [IDXW-1:0] elem_idx_q, elem_idx_d;
  logic            is_store_q, is_store_d;
  logic            handshake, last_elem;

  logic issue_ready_c, alu_en_c, div_start_c, mem_req_c, mem_we_c;
  logic sreg_we_c, vreg_we_c, stall_c, done_c;

  // Class decode of {funct, opcode[2:0], imm}; unlisted encodings retire as ILLEGAL.
  always_comb begin
    accept_state = S_FIN;
    casez (bus.ex_ctrl)
      5'b1????:                   accept_state = S_MEM;
      5'b0000?, 5'b0010?, 5'b0011?: accept_state = S_SCALAR;
      5'b0001?, 5'b0100?, 5'b0101?: accept_state = S_VEC;
      5'b0110?:                   accept_state = S_DIV_START;
      default:                    accept_state = S_FIN;
    endcase
  end

  assign handshake = bus.issue_valid & issue_ready_c;
  assign last_elem = (elem_idx_q == LAST_IDX);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d       = state_q;
    elem_idx_d    = elem_idx_q;
    is_store_d    = is_store_q;
    issue_ready_c = 1'b0;
    alu_en_c      = 1'b0;
    div_start_c   = 1'b0;
    mem_req_c     = 1'b0;
    mem_we_c      = 1'b0;
    sreg_we_c     = 1'b0;
    vreg_we_c     = 1'b0;
    done_c        = 1'b0;

    case (state_q)
      S_IDLE: begin
        issue_ready_c = 1'b1;
        if (handshake) begin
          state_d    = accept_state;
          elem_idx_d = '0;
          is_store_d = bus.ex_ctrl[4] & bus.ex_ctrl[1];
        end
      end

      S_SCALAR: begin
        alu_en_c  = 1'b1;
        sreg_we_c = 1'b1;
        state_d   = S_FIN;
      end

      S_VEC: begin
        alu_en_c  = 1'b1;
        vreg_we_c = 1'b1;
        if (last_elem) state_d    = S_FIN;
        else           elem_idx_d = elem_idx_q + IDXW'(1);
      end

      // div_done is not looked at here: a result cannot belong to this launch yet.
      S_DIV_START: begin
        div_start_c = 1'b1;
        state_d     = S_DIV_WAIT;
      end

      S_DIV_WAIT: begin
        if (bus.div_done) begin
          vreg_we_c = 1'b1;
          if (last_elem) begin
            state_d = S_FIN;
          end else begin
            elem_idx_d = elem_idx_q + IDXW'(1);
            state_d    = S_DIV_START;
          end
        end
      end

      S_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = is_store_q;
        if (bus.mem_ack) begin
          vreg_we_c = ~is_store_q;
          if (last_elem) state_d    = S_FIN;
          else           elem_idx_d = elem_idx_q + IDXW'(1);
        end
      end

      S_FIN: begin
        done_c     = 1'b1;
        is_store_d = 1'b0;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign stall_c = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      elem_idx_q <= '0;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      elem_idx_q <= elem_idx_d;
      is_store_q <= is_store_d;
    end
  end

  // Reset silences every output in the same cycle, so an abort never leaks a request.
  assign bus.issue_ready = issue_ready_c & ~rst;
  assign bus.elem_idx    = rst ? '0 : elem_idx_q;
  assign bus.alu_en      = alu_en_c    & ~rst;
  assign bus.div_start   = div_start_c & ~rst;
  assign bus.mem_req     = mem_req_c   & ~rst;
  assign bus.mem_we      = mem_we_c    & ~rst;
  assign bus.sreg_we     = sreg_we_c   & ~rst;
  assign bus.vreg_we     = vreg_we_c   & ~rst;
  assign bus.stall       = stall_c     & ~rst;
  assign bus.done        = done_c      & ~rst;

`ifdef VSEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_count <= '0;
      busy_cycles <= '0;
    end else begin
      if (done_c && !(&instr_count))  instr_count <= instr_count + CNTW'(1);
      if (stall_c && !(&busy_cycles)) busy_cycles <= busy_cycles + CNTW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vector_op_sequencer.sv
// Self-checking bench for vector_op_sequencer: a cycle-level expected trace is built
// from the instruction-class rules, then replayed against the DUT.
module tb_vector_op_sequencer;
  localparam int VLEN = 8;
  localparam int IDXW = $clog2(VLEN);

  localparam logic [8:0] F_RDY = 9'h100, F_ALU = 9'h080, F_DS = 9'h040;
  localparam logic [8:0] F_MR  = 9'h020, F_MW  = 9'h010, F_SW = 9'h008;
  localparam logic [8:0] F_VW  = 9'h004, F_ST  = 9'h002, F_DN = 9'h001;

  typedef enum {C_SCALAR, C_VEC, C_DIV, C_MEM, C_ILL} cls_t;

  typedef struct {
    bit         iv;
    logic [4:0] ctrl;
    bit         dd;
    bit         ma;
    bit         r;
    logic [8:0] f;
    int         idx;
    string      tag;
  } step_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  step_t q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    idle_idx    = 0;

  vector_op_sequencer_if #(.VLEN(VLEN)) bus ();

`ifdef VSEQ_PERF_CNT_EN
  logic [15:0] instr_count, busy_cycles;
  vector_op_sequencer #(.VLEN(VLEN), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .instr_count(instr_count), .busy_cycles(busy_cycles), .bus(bus)
  );
`else
  vector_op_sequencer #(.VLEN(VLEN)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic logic [4:0] rc();
    return 5'($urandom);
  endfunction

  function automatic void add(bit iv, logic [4:0] c, bit dd, bit ma, bit r,
                              logic [8:0] f, int idx, string tag);
    step_t s;
    s.iv = iv; s.ctrl = c; s.dd = dd; s.ma = ma; s.r = r;
    s.f = f; s.idx = idx; s.tag = tag;
    q.push_back(s);
  endfunction

  function automatic cls_t classify(logic [4:0] c);
    logic [2:0] op = c[3:1];
    if (c[4]) return C_MEM;
    if (op inside {3'd0, 3'd2, 3'd3}) return C_SCALAR;
    if (op inside {3'd1, 3'd4, 3'd5}) return C_VEC;
    if (op == 3'd6) return C_DIV;
    return C_ILL;
  endfunction

  function automatic void idle(int n);
    for (int i = 0; i < n; i++) add(1'b0, rc(), rb(), rb(), 1'b0, F_RDY, idle_idx, "idle");
  endfunction

  function automatic void reset(int n);
    for (int i = 0; i < n; i++) add(rb(), rc(), rb(), rb(), 1'b1, 9'h0, 0, "reset");
    idle_idx = 0;
  endfunction

  // div_lat <= 0 or mem_wait < 0 pick a random latency per element.
  function automatic void instr(logic [4:0] c, int div_lat, int mem_wait,
                                int slow_elem, int slow_wait);
    cls_t       k  = classify(c);
    bit         st = c[4] & c[1];
    logic [8:0] mb = F_MR | F_ST | (st ? F_MW : 9'h0);
    add(1'b1, c, rb(), rb(), 1'b0, F_RDY, idle_idx, "handshake");
    case (k)
      C_SCALAR: add(rb(), rc(), rb(), rb(), 1'b0, F_ALU | F_SW | F_ST, 0, "scalar");
      C_VEC:
        for (int e = 0; e < VLEN; e++)
          add(rb(), rc(), rb(), rb(), 1'b0, F_ALU | F_VW | F_ST, e, "vec");
      C_DIV:
        for (int e = 0; e < VLEN; e++) begin
          int l = (div_lat > 0) ? div_lat : int'($urandom_range(1, 4));
          add(rb(), rc(), rb(), rb(), 1'b0, F_DS | F_ST, e, "div_start");
          for (int w = 1; w < l; w++) add(rb(), rc(), 1'b0, rb(), 1'b0, F_ST, e, "div_wait");
          add(rb(), rc(), 1'b1, rb(), 1'b0, F_VW | F_ST, e, "div_done");
        end
      C_MEM:
        for (int e = 0; e < VLEN; e++) begin
          int w = (e == slow_elem) ? slow_wait
                : (mem_wait >= 0) ? mem_wait : int'($urandom_range(0, 3));
          for (int j = 0; j < w; j++) add(rb(), rc(), rb(), 1'b0, 1'b0, mb, e, "mem_wait");
          add(rb(), rc(), rb(), 1'b1, 1'b0, mb | (st ? 9'h0 : F_VW), e, "mem_ack");
        end
      default: ;
    endcase
    add(rb(), rc(), rb(), rb(), 1'b0, F_ST | F_DN,
        (k == C_SCALAR || k == C_ILL) ? 0 : -1, "fin");
    idle_idx = (k == C_SCALAR || k == C_ILL) ? 0 : -1;
  endfunction

  initial begin
    logic [8:0] obs;
    bit         perf_valid = 1'b0;
    int         exp_instr  = 0;
    int         exp_busy   = 0;

    bus.issue_valid = 1'b0;
    bus.ex_ctrl     = 5'b0;
    bus.div_done    = 1'b0;
    bus.mem_ack     = 1'b0;

    // Directed plan
    reset(2); idle(2);
    instr(5'b01010, 0, 0, -1, 0);            // VEC
    instr(5'b00101, 0, 0, -1, 0);            // SCALAR back-to-back
    idle(1);
    instr(5'b01100, 3, 0, -1, 0);            // DIV, done 3 cycles after each start
    instr(5'b10010, 0, 0, 3, 2);             // store, element 3 acked late
    instr(5'b10000, 0, 0, 3, 2);             // load, same timing

    // Reset mid-VEC at element 4, late acks ignored, fresh VEC after
    add(1'b1, 5'b01010, 1'b0, 1'b0, 1'b0, F_RDY, idle_idx, "handshake");
    for (int e = 0; e < 4; e++) add(rb(), rc(), rb(), rb(), 1'b0, F_ALU | F_VW | F_ST, e, "vec");
    add(1'b1, rc(), 1'b1, 1'b1, 1'b1, 9'h0, 0, "rst_mid_vec");
    idle_idx = 0;
    add(1'b0, rc(), 1'b1, 1'b1, 1'b0, F_RDY, 0, "post_rst");
    instr(5'b01010, 0, 0, -1, 0);

    // ILLEGAL right after reset
    reset(1);
    instr(5'b01110, 0, 0, -1, 0);
    idle(2);

    // Reset while a store waits for mem_ack
    add(1'b1, 5'b10011, 1'b0, 1'b0, 1'b0, F_RDY, idle_idx, "handshake");
    for (int j = 0; j < 2; j++) add(rb(), rc(), rb(), 1'b0, 1'b0, F_MR | F_MW | F_ST, 0, "mem_wait");
    add(1'b0, rc(), 1'b1, 1'b1, 1'b1, 9'h0, 0, "rst_mid_mem");
    idle_idx = 0;
    add(1'b0, rc(), 1'b1, 1'b1, 1'b0, F_RDY, 0, "post_rst");

    // Randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      idle(int'($urandom_range(0, 2)));
      instr(rc(), -1, -1, -1, 0);
    end
    reset(1); idle(1);

    // Replay
    foreach (q[i]) begin
      @(posedge clk); #1;
      rst             = q[i].r;
      bus.issue_valid = q[i].iv;
      bus.ex_ctrl     = q[i].ctrl;
      bus.div_done    = q[i].dd;
      bus.mem_ack     = q[i].ma;
      @(negedge clk);
      obs = {bus.issue_ready, bus.alu_en, bus.div_start, bus.mem_req, bus.mem_we,
             bus.sreg_we, bus.vreg_we, bus.stall, bus.done};
      chk($sformatf("%s[%0d] flags", q[i].tag, i), 32'(obs), 32'(q[i].f));
      if (q[i].idx >= 0)
        chk($sformatf("%s[%0d] elem_idx", q[i].tag, i), 32'(bus.elem_idx), 32'(q[i].idx));
`ifdef VSEQ_PERF_CNT_EN
      if (perf_valid) begin
        chk($sformatf("%s[%0d] instr_count", q[i].tag, i), 32'(instr_count), 32'(exp_instr));
        chk($sformatf("%s[%0d] busy_cycles", q[i].tag, i), 32'(busy_cycles), 32'(exp_busy));
      end
`endif
      if (q[i].r) begin
        perf_valid = 1'b1;
        exp_instr  = 0;
        exp_busy   = 0;
      end else begin
        exp_instr += int'(q[i].f[0]);
        exp_busy  += int'(q[i].f[1]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
